wm_eval_sched: RTL and testbench
================================

Name: wm_eval_sched

Overview:
Sequencer and configuration controller for the weighted-majority trend datapath. It captures the serial sample stream into a WIN-deep window. On each sample strobe it schedules one serial weighted-sum evaluation, processing one tap per cycle through a single shared adder. It then compares the result against half the total weight and publishes a trend decision. It also owns the programmable per-tap weight registers, which are written through a simple config port.

Parameters:
WIN, 8, window depth in taps; tap 0 is the newest sample.
WW, 4, weight width in bits.
HYST, 2, hysteresis margin; used only when WM_HYST_EN is defined.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
bit_in  in  1  serial sample
bit_vld  in  1  sample strobe; bit_in is valid this cycle
cfg_we  in  1  weight write request
cfg_addr  in  clog2(WIN)  tap index to write
cfg_wdata  in  WW  weight value
cfg_ack  out  1  one-cycle pulse; the write was accepted
busy  out  1  high when state is not IDLE
trend_vld  out  1  one-cycle pulse; trend and score were updated
trend  out  1  1 = ones-majority (rising), 0 = zeros-majority
score  out  SW  weighted sum of ones from the last evaluation; SW = WW+clog2(WIN)+1
ovf  out  1  sticky flag: a sample strobe was coalesced (lost evaluation)

Behaviour:
- Reset, on the clk edge with rst=1:
  - window = 0, weights[i] = WIN-i (default 8..1, total 36).
  - state = IDLE, pending = 0.
  - trend, trend_vld, score, ovf, cfg_ack, busy all 0.
  - rst has priority over every other input. Reset during ACCUM or DECIDE aborts the evaluation with no trend_vld.
- Window: on every bit_vld, in any state, window <= {window[WIN-2:0], bit_in}.
- Snapshot: when an evaluation starts, the window and weights are copied into a snapshot. Later shifts do not disturb the evaluation in flight.
- FSM states: IDLE, ACCUM, DECIDE.
  - IDLE: bit_vld -> ACCUM. Snapshot taken with the new bit included; tap counter = 0; accumulators cleared.
  - ACCUM: one tap per cycle.
    - score_acc += snap_bit[k] ? w[k] : 0
    - total_acc += w[k]
    - After k = WIN-1 -> DECIDE.
  - DECIDE: registers outputs and pulses trend_vld.
    - If 2*score_acc > total_acc, trend = 1.
    - If 2*score_acc < total_acc, trend = 0.
    - If equal, trend holds its previous value.
    - score <= score_acc.
    - Next state: if pending, go to ACCUM with a fresh snapshot and clear pending; otherwise go to IDLE.
- Latency: trend_vld is asserted WIN+1 cycles after the edge that sampled bit_vld (9 cycles at WIN=8).
- Sample strobes while busy:
  - The first strobe sets pending.
  - A strobe arriving while pending is already 1 sets ovf. The shift still occurs and the evaluations coalesce.
  - A strobe during DECIDE that also consumes pending counts as setting pending again, not as overflow.
- Config writes:
  - Accepted only when busy=0 and there is no bit_vld in the same cycle. The weight is updated and cfg_ack pulses the next cycle.
  - Otherwise the write is dropped with no cfg_ack; the requester must retry.
  - cfg_addr >= WIN is dropped with no cfg_ack.
- Arithmetic: all unsigned. Accumulators are SW bits wide and cannot overflow. The 2*score compare uses SW+1 bits.

Optional Feature:
WM_HYST_EN
- Defined: the comparison uses the HYST margin.
  - trend is set to 1 only if 2*score > total+HYST.
  - trend is cleared to 0 only if 2*score+HYST < total.
  - Any other result holds trend.
- Undefined: plain compare as specified above; HYST is unused.

Decomposition:
- Package wm_pkg holds:
  - WIN, WW, SW constants.
  - State typedef enum {IDLE, ACCUM, DECIDE}.
  - Weight typedef logic [WW-1:0].
- One sub-module, wm_weight_regfile:
  - WIN x WW registers with reset defaults WIN-i.
  - Write port gated by the scheduler.
  - Combinational read by tap index.
- The FSM, accumulators, window and snapshot live in wm_eval_sched.

Test Plan:
1. Reset, then idle 5 cycles -> busy=0, trend=0, trend_vld=0, score=0, ovf=0, cfg_ack=0.
2. Default weights; strobe 4 zeros then ones, each 12 cycles apart:
   - 1st one: score=8, trend=0.
   - 2nd one: score=15, trend=0.
   - 3rd one: score=21, trend=1.
   - 5th one: score=30, trend=1.
   - Each trend_vld exactly 9 cycles after its strobe.
3. Write all weights = 1 (8 writes while idle, 8 cfg_acks). Window 10101010 -> score=4 (tie with total 8), trend holds prior value. Window 11101010 -> score=5, trend=1.
4. bit_vld on two consecutive cycles -> two trend_vld pulses 9 cycles apart, ovf=0. Three strobes within one busy period -> ovf=1, and ovf stays 1 until rst.
5. cfg_we during ACCUM to tap 0 with value 15 -> no cfg_ack; the next evaluation still uses weight 8.
6. rst asserted during ACCUM -> next cycle busy=0, no trend_vld, window=0, weights back to 8..1.

Source files
------------

// File: rtl/wm_pkg.sv
// wm_pkg: shared constants and types for the weighted-majority trend scheduler
package wm_pkg;
  localparam int WIN = 8;
  localparam int WW = 4;
  localparam int HYST = 2;
  localparam int AW = $clog2(WIN);
  localparam int SW = WW + AW + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE} state_t;
  typedef logic [WW-1:0] weight_t;
endpackage

// File: rtl/wm_weight_regfile.sv
// wm_weight_regfile: per-tap weight registers, reset to WIN-i, combinational read by tap
module wm_weight_regfile
  import wm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WW-1:0] rdata
);
  weight_t w [WIN];
  always_ff @(posedge clk)
    for (int i = 0; i < WIN; i++)
      if (rst) w[i] <= WW'(WIN - i);
      else if (we && waddr == AW'(i)) w[i] <= wdata;
  assign rdata = w[raddr];
endmodule

// File: rtl/wm_eval_sched.sv
// wm_eval_sched: sample window, serial weighted-sum evaluation and trend decision
// Optional hysteresis compare enabled by defining WM_HYST_EN.
module wm_eval_sched
  import wm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          bit_in,
  input  logic          bit_vld,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [WW-1:0] cfg_wdata,
  output logic          cfg_ack,
  output logic          busy,
  output logic          trend_vld,
  output logic          trend,
  output logic [SW-1:0] score,
  output logic          ovf
);
  state_t state;
  logic [WIN-1:0] window, snap, win_nx;
  logic [AW-1:0] k;
  logic [SW-1:0] score_acc, total_acc;
  logic [WW-1:0] w_k;
  logic [SW:0] two_s, tot;
  logic pending, cfg_ok, rise, fall;
  assign win_nx = bit_vld ? {window[WIN-2:0], bit_in} : window;
  assign cfg_ok = cfg_we && state == IDLE && !bit_vld && {1'b0, cfg_addr} < (AW+1)'(WIN);
  assign two_s = {score_acc, 1'b0};
  assign tot = {1'b0, total_acc};
`ifdef WM_HYST_EN
  assign rise = two_s > tot + (SW+1)'(HYST);
  assign fall = two_s + (SW+1)'(HYST) < tot;
`else
  assign rise = two_s > tot;
  assign fall = two_s < tot;
`endif
  // Weights only change while idle with no strobe, so the live read equals a snapshot.
  wm_weight_regfile u_regs (
    .clk  (clk),
    .rst  (rst),
    .we   (cfg_ok),
    .waddr(cfg_addr),
    .wdata(cfg_wdata),
    .raddr(k),
    .rdata(w_k)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      window <= '0;
      snap <= '0;
      k <= '0;
      score_acc <= '0;
      total_acc <= '0;
      pending <= 1'b0;
      trend <= 1'b0;
      trend_vld <= 1'b0;
      score <= '0;
      ovf <= 1'b0;
      cfg_ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      window <= win_nx;
      cfg_ack <= cfg_ok;
      trend_vld <= 1'b0;
      case (state)
        IDLE: if (bit_vld) begin
          state <= ACCUM;
          busy <= 1'b1;
          snap <= win_nx;
          k <= '0;
          score_acc <= '0;
          total_acc <= '0;
        end
        ACCUM: begin
          score_acc <= score_acc + (snap[k] ? SW'(w_k) : '0);
          total_acc <= total_acc + SW'(w_k);
          k <= k + 1'b1;
          if (k == AW'(WIN - 1)) state <= DECIDE;
          if (bit_vld) begin
            pending <= 1'b1;
            ovf <= ovf | pending;
          end
        end
        DECIDE: begin
          trend_vld <= 1'b1;
          score <= score_acc;
          trend <= rise ? 1'b1 : fall ? 1'b0 : trend;
          // A strobe landing here restarts immediately; if pending was also set it re-arms pending.
          if (pending || bit_vld) begin
            state <= ACCUM;
            snap <= win_nx;
            k <= '0;
            score_acc <= '0;
            total_acc <= '0;
            pending <= pending && bit_vld;
          end else begin
            state <= IDLE;
            busy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wm_eval_sched.sv
// tb_wm_eval_sched: directed plus randomized checks against a weighted-majority reference model
module tb_wm_eval_sched;
  import wm_pkg::*;
  logic clk = 1'b0;
  logic rst, bit_in, bit_vld, cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [WW-1:0] cfg_wdata;
  logic cfg_ack, busy, trend_vld, trend, ovf;
  logic [SW-1:0] score;
  int checks = 0;
  int failures = 0;
  int m_bits[WIN];
  int m_w[WIN];
  int m_trend;
  int pat_a[8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  int pat_b[8] = '{1, 1, 1, 0, 1, 0, 1, 0};

  always #5 clk = ~clk;

  wm_eval_sched dut (
    .clk      (clk),
    .rst      (rst),
    .bit_in   (bit_in),
    .bit_vld  (bit_vld),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_ack  (cfg_ack),
    .busy     (busy),
    .trend_vld(trend_vld),
    .trend    (trend),
    .score    (score),
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < WIN; i++) begin
      m_bits[i] = 0;
      m_w[i] = WIN - i;
    end
    m_trend = 0;
  endtask

  task automatic push(input int b);
    for (int i = WIN - 1; i > 0; i--) m_bits[i] = m_bits[i-1];
    m_bits[0] = b;
  endtask

  // Weighted majority over the current model window; trend updates in evaluation order.
  task automatic model_eval(output int s, output int t);
    int tot;
    tot = 0;
    s = 0;
    for (int i = 0; i < WIN; i++) begin
      tot += m_w[i];
      if (m_bits[i] != 0) s += m_w[i];
    end
`ifdef WM_HYST_EN
    if (2 * s > tot + HYST) m_trend = 1;
    else if (2 * s + HYST < tot) m_trend = 0;
`else
    if (2 * s > tot) m_trend = 1;
    else if (2 * s < tot) m_trend = 0;
`endif
    t = m_trend;
  endtask

  task automatic strobe(input int b);
    bit_vld = 1'b1;
    bit_in = b[0];
    step;
    bit_vld = 1'b0;
    push(b);
  endtask

  task automatic wait_vld(input string tag, input int exp_n, input int exp_s, input int exp_t);
    int n;
    n = 0;
    do begin
      step;
      n++;
    end while (!trend_vld && n < 20);
    chk({tag, "_lat"}, n, exp_n);
    chk({tag, "_score"}, score, exp_s);
    chk({tag, "_trend"}, trend, exp_t);
  endtask

  task automatic eval(input string tag, input int b);
    int s, t;
    strobe(b);
    model_eval(s, t);
    chk({tag, "_busy"}, busy, 1);
    wait_vld(tag, 9, s, t);
    step;
    step;
  endtask

  task automatic cfg(input int a, input int d);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_wdata = WW'(d);
    step;
    cfg_we = 1'b0;
    chk("cfg_ack", cfg_ack, 1);
    m_w[a] = d;
  endtask

  initial begin
    int a, b, c, s1, t1, s2, t2, pulses;
    rst = 1'b1;
    bit_in = 1'b0;
    bit_vld = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    model_reset;
    step;
    rst = 1'b0;
    repeat (5) step;
    chk("rst_busy", busy, 0);
    chk("rst_trend", trend, 0);
    chk("rst_trend_vld", trend_vld, 0);
    chk("rst_score", score, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_cfg_ack", cfg_ack, 0);

    repeat (4) eval("zero", 0);
    eval("one1", 1);
    chk("one1_const", score, 8);
    chk("one1_trend_const", trend, 0);
    eval("one2", 1);
    chk("one2_const", score, 15);
    chk("one2_trend_const", trend, 0);
    eval("one3", 1);
    chk("one3_const", score, 21);
    chk("one3_trend_const", trend, 1);
    eval("one4", 1);
    eval("one5", 1);
    chk("one5_const", score, 30);
    chk("one5_trend_const", trend, 1);

    for (int i = 0; i < WIN; i++) cfg(i, 1);
    step;
    chk("cfg_ack_pulse", cfg_ack, 0);
    foreach (pat_a[i]) eval("pat_a", pat_a[i]);
    chk("tie_score", score, 4);
    chk("tie_trend_hold", trend, 1);
    foreach (pat_b[i]) eval("pat_b", pat_b[i]);
    chk("pat_b_score", score, 5);
    chk("pat_b_trend", trend, 1);

    a = $urandom_range(1);
    b = $urandom_range(1);
    bit_vld = 1'b1;
    bit_in = a[0];
    step;
    push(a);
    model_eval(s1, t1);
    bit_in = b[0];
    step;
    bit_vld = 1'b0;
    push(b);
    model_eval(s2, t2);
    wait_vld("pair1", 8, s1, t1);
    wait_vld("pair2", 9, s2, t2);
    chk("pair_ovf", ovf, 0);
    step;
    step;
    a = $urandom_range(1);
    b = $urandom_range(1);
    c = $urandom_range(1);
    bit_vld = 1'b1;
    bit_in = a[0];
    step;
    push(a);
    model_eval(s1, t1);
    bit_in = b[0];
    step;
    push(b);
    bit_in = c[0];
    step;
    push(c);
    bit_vld = 1'b0;
    model_eval(s2, t2);
    chk("tri_ovf", ovf, 1);
    wait_vld("tri1", 7, s1, t1);
    wait_vld("tri2", 9, s2, t2);
    eval("post_ovf", $urandom_range(1));
    chk("ovf_sticky", ovf, 1);

    strobe(1);
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    model_reset;
    chk("abort_busy", busy, 0);
    chk("abort_trend_vld", trend_vld, 0);
    chk("abort_trend", trend, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_score", score, 0);
    pulses = 0;
    repeat (12) begin
      step;
      pulses += int'(trend_vld);
    end
    chk("abort_no_vld", pulses, 0);
    eval("abort_w0", 1);
    chk("abort_w0_const", score, 8);
    repeat (7) eval("abort_ones", 1);
    chk("abort_all_const", score, 36);

    strobe(1);
    model_eval(s1, t1);
    step;
    step;
    cfg_we = 1'b1;
    cfg_addr = '0;
    cfg_wdata = 4'd15;
    step;
    cfg_we = 1'b0;
    chk("busy_cfg_ack", cfg_ack, 0);
    wait_vld("busy_cfg", 6, s1, t1);
    step;
    eval("after_drop", 1);
    chk("after_drop_const", score, 36);
    cfg_we = 1'b1;
    cfg_addr = AW'(1);
    cfg_wdata = '0;
    bit_vld = 1'b1;
    bit_in = 1'b1;
    step;
    cfg_we = 1'b0;
    bit_vld = 1'b0;
    push(1);
    model_eval(s1, t1);
    chk("vld_cfg_ack", cfg_ack, 0);
    wait_vld("vld_cfg", 9, s1, t1);
    step;

    repeat (12) begin
      if ($urandom_range(1) == 1) cfg($urandom_range(WIN - 1), $urandom_range((1 << WW) - 1));
      eval("rand", $urandom_range(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
